// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM.
// Sequences FETCH/DECODE/EXEC/MEM/WB, stalls on the memory ready handshake and
// counts mult/divu latency in MDWAIT. Datapath controls are combinational decodes
// of the current state, the IR fields and the zero/mem_ready flags.
module multi_cycle_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       jsrc,
  output logic       jadr,
  output logic       reg_write,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       hilo_sel,
  output logic       alusrc,
  output logic [1:0] aluop,
  output logic [1:0] extop,
  output logic       md_start,
  output logic       md_op,
  output logic       md_busy,
  output logic       retire,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StMdWait = 3'd5
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnDivu  = 6'h1b;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;

  // Counter preload: MDWAIT lasts LAT cycles, the last one being cnt==0.
  localparam logic [CNT_W-1:0] MultCnt = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DivCnt  = CNT_W'(DIV_LAT - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;

  logic is_rtype, is_addu, is_subu, is_jr, is_mfhi, is_mflo, is_mult, is_divu;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_md, is_known;

  // Instruction class decode from the IR fields
  always_comb begin
    is_rtype = (opcode == OpRtype);
    is_addu  = is_rtype && (funct == FnAddu);
    is_subu  = is_rtype && (funct == FnSubu);
    is_jr    = is_rtype && (funct == FnJr);
    is_mfhi  = is_rtype && (funct == FnMfhi);
    is_mflo  = is_rtype && (funct == FnMflo);
    is_mult  = is_rtype && (funct == FnMult);
    is_divu  = is_rtype && (funct == FnDivu);
    is_ori   = (opcode == OpOri);
    is_lui   = (opcode == OpLui);
    is_lw    = (opcode == OpLw);
    is_sw    = (opcode == OpSw);
    is_beq   = (opcode == OpBeq);
    is_jal   = (opcode == OpJal);
    is_md    = is_mult || is_divu;
    // nop and anything undefined fall outside this set and retire in DECODE
    is_known = is_addu || is_subu || is_jr || is_mfhi || is_mflo || is_md ||
               is_ori || is_lui || is_lw || is_sw || is_beq || is_jal;
  end

  // State sequencing and latency counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          if (mem_ready) state_q <= StDecode;
        end
        StDecode: begin
          if (is_jal || is_jr || !is_known) state_q <= StFetch;
          else if (is_mfhi || is_mflo)      state_q <= StWb;
          else                              state_q <= StExec;
        end
        StExec: begin
          if (is_lw || is_sw) begin
            state_q <= StMem;
          end else if (is_beq) begin
            state_q <= StFetch;
          end else if (is_md) begin
            cnt_q   <= is_divu ? DivCnt : MultCnt;
            state_q <= StMdWait;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (mem_ready) state_q <= is_lw ? StWb : StFetch;
        end
        StWb: begin
          state_q <= StFetch;
        end
        StMdWait: begin
          if (cnt_q == '0) state_q <= StFetch;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: begin
          state_q <= StFetch;
        end
      endcase
    end
  end

  // Datapath control decode; strobes are squashed while reset is asserted
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    jsrc      = 1'b0;
    jadr      = 1'b0;
    reg_write = 1'b0;
    regdst    = 2'd0;
    memtoreg  = 2'd0;
    hilo_sel  = 1'b0;
    alusrc    = 1'b0;
    aluop     = 2'd0;
    extop     = 2'd0;
    md_start  = 1'b0;
    md_op     = 1'b0;
    md_busy   = 1'b0;
    retire    = 1'b0;

    case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      StDecode: begin
        if (is_jal) begin
          pc_write  = 1'b1;
          jsrc      = 1'b1;
          regdst    = 2'd2;
          memtoreg  = 2'd2;
          reg_write = 1'b1;
          retire    = 1'b1;
        end else if (is_jr) begin
          pc_write = 1'b1;
          jsrc     = 1'b1;
          jadr     = 1'b1;
          retire   = 1'b1;
        end else if (!is_known) begin
          retire = 1'b1;
        end
      end
      StExec: begin
        if (is_subu) begin
          aluop = 2'd1;
        end else if (is_ori) begin
          alusrc = 1'b1;
          aluop  = 2'd2;
        end else if (is_lui) begin
          // rs is $0 for lui, so add passes the shifted immediate through
          alusrc = 1'b1;
          extop  = 2'd2;
        end else if (is_lw || is_sw) begin
          alusrc = 1'b1;
          extop  = 2'd1;
        end else if (is_beq) begin
          aluop    = 2'd1;
          extop    = 2'd1;
          pc_write = zero;
          retire   = 1'b1;
        end else if (is_md) begin
          md_start = 1'b1;
          md_op    = is_divu;
        end
      end
      StMem: begin
        if (is_lw) begin
          mem_read = 1'b1;
        end else if (is_sw) begin
          mem_write = 1'b1;
          retire    = mem_ready;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        if (is_lw) begin
          memtoreg = 2'd1;
        end else if (is_mfhi || is_mflo) begin
          regdst   = 2'd1;
          memtoreg = 2'd3;
          hilo_sel = is_mfhi;
        end else if (is_addu || is_subu) begin
          regdst = 2'd1;
        end
      end
      StMdWait: begin
        md_busy = 1'b1;
        retire  = (cnt_q == '0);
      end
      default: begin
      end
    endcase

    if (!reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      md_start  = 1'b0;
      retire    = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: each cycle's stimulus is driven together
// with the expected control word, which is popped and compared on the falling edge.
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       md_start;
    logic       md_busy;
    logic       retire;
    logic       jsrc;
    logic       jadr;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       hilo_sel;
    logic       alusrc;
    logic [1:0] aluop;
    logic [1:0] extop;
    logic       md_op;
  } obs_t;

  localparam logic [2:0] SFetch = 3'd0, SDecode = 3'd1, SExec = 3'd2, SMem = 3'd3,
                         SWb = 3'd4, SMdWait = 3'd5;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_read, mem_write, ir_write, pc_write, jsrc, jadr, reg_write;
  logic [1:0] regdst, memtoreg, aluop, extop;
  logic       hilo_sel, alusrc, md_start, md_op, md_busy, retire;
  logic [2:0] state;

  obs_t got;
  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .jsrc      (jsrc),
    .jadr      (jadr),
    .reg_write (reg_write),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .hilo_sel  (hilo_sel),
    .alusrc    (alusrc),
    .aluop     (aluop),
    .extop     (extop),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_busy   (md_busy),
    .retire    (retire),
    .state     (state)
  );

  assign got = {state, mem_read, mem_write, ir_write, pc_write, reg_write, md_start, md_busy,
                retire, jsrc, jadr, regdst, memtoreg, hilo_sel, alusrc, aluop, extop, md_op};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, req);
    end
  endtask

  function automatic obs_t st(input logic [2:0] s);
    obs_t o;
    o = '0;
    o.state = s;
    return o;
  endfunction

  // One clock: drive inputs, push the expectation, compare on the falling edge.
  task automatic cyc(input string tag, input logic rdy, input logic rst, input obs_t e);
    obs_t x;
    mem_ready = rdy;
    reset     = rst;
    exp_q.push_back(e);
    @(negedge clk);
    check_eq({tag, ":sb"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check_eq(tag, 32'(got), 32'(x));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
  endtask

  task automatic fetch_ok(input string t);
    obs_t e = st(SFetch);
    e.mem_read = 1'b1;
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    cyc({t, ":fetch"}, 1'b1, 1'b1, e);
  endtask

  // mem_ready is held low in DECODE/EXEC/WB to show it is ignored there
  task automatic dec_plain(input string t);
    cyc({t, ":dec"}, 1'b0, 1'b1, st(SDecode));
  endtask

  task automatic exec(input string t, input logic src, input logic [1:0] op,
                      input logic [1:0] ext);
    obs_t e = st(SExec);
    e.alusrc = src;
    e.aluop  = op;
    e.extop  = ext;
    cyc({t, ":exec"}, 1'b0, 1'b1, e);
  endtask

  task automatic wb(input string t, input logic [1:0] rd, input logic [1:0] mtr,
                    input logic hs);
    obs_t e = st(SWb);
    e.reg_write = 1'b1;
    e.retire    = 1'b1;
    e.regdst    = rd;
    e.memtoreg  = mtr;
    e.hilo_sel  = hs;
    cyc({t, ":wb"}, 1'b0, 1'b1, e);
  endtask

  task automatic md_run(input string t, input logic dv, input int lat);
    obs_t e = st(SExec);
    e.md_start = 1'b1;
    e.md_op    = dv;
    cyc({t, ":exec"}, 1'b0, 1'b1, e);
    for (int i = 0; i < lat; i++) begin
      e = st(SMdWait);
      e.md_busy = 1'b1;
      e.retire  = (i == lat - 1);
      cyc($sformatf("%s:mdw%0d", t, i), 1'b1, 1'b1, e);
    end
  endtask

  initial begin
    obs_t e;
    set_ir(6'h00, 6'h21, 1'b0);

    // Reset: FETCH state, all strobes forced low even with mem_ready high
    cyc("rst0", 1'b1, 1'b0, st(SFetch));
    cyc("rst1", 1'b1, 1'b0, st(SFetch));

    // addu with a two-cycle fetch stall
    e = st(SFetch);
    e.mem_read = 1'b1;
    cyc("fstall0", 1'b0, 1'b1, e);
    cyc("fstall1", 1'b0, 1'b1, e);
    fetch_ok("addu"); dec_plain("addu"); exec("addu", 1'b0, 2'd0, 2'd0);
    wb("addu", 2'd1, 2'd0, 1'b0);

    set_ir(6'h00, 6'h23, 1'b1);
    fetch_ok("subu"); dec_plain("subu"); exec("subu", 1'b0, 2'd1, 2'd0);
    wb("subu", 2'd1, 2'd0, 1'b0);

    set_ir(6'h0d, 6'h3f, 1'b0);
    fetch_ok("ori"); dec_plain("ori"); exec("ori", 1'b1, 2'd2, 2'd0);
    wb("ori", 2'd0, 2'd0, 1'b0);

    set_ir(6'h0f, 6'h00, 1'b0);
    fetch_ok("lui"); dec_plain("lui"); exec("lui", 1'b1, 2'd0, 2'd2);
    wb("lui", 2'd0, 2'd0, 1'b0);

    // lw with mem_ready low for two MEM cycles: 7 cycles total
    set_ir(6'h23, 6'h00, 1'b0);
    fetch_ok("lw"); dec_plain("lw"); exec("lw", 1'b1, 2'd0, 2'd1);
    e = st(SMem);
    e.mem_read = 1'b1;
    cyc("lw:mem0", 1'b0, 1'b1, e);
    cyc("lw:mem1", 1'b0, 1'b1, e);
    cyc("lw:mem2", 1'b1, 1'b1, e);
    wb("lw", 2'd0, 2'd1, 1'b0);

    set_ir(6'h2b, 6'h00, 1'b0);
    fetch_ok("sw"); dec_plain("sw"); exec("sw", 1'b1, 2'd0, 2'd1);
    e = st(SMem);
    e.mem_write = 1'b1;
    e.retire    = 1'b1;
    cyc("sw:mem", 1'b1, 1'b1, e);

    // beq taken and not taken
    for (int z = 1; z >= 0; z--) begin
      set_ir(6'h04, 6'h00, z[0]);
      fetch_ok("beq"); dec_plain("beq");
      e = st(SExec);
      e.aluop    = 2'd1;
      e.extop    = 2'd1;
      e.pc_write = z[0];
      e.retire   = 1'b1;
      cyc($sformatf("beq_z%0d:exec", z), 1'b0, 1'b1, e);
    end

    set_ir(6'h03, 6'h00, 1'b0);
    fetch_ok("jal");
    e = st(SDecode);
    e.pc_write  = 1'b1;
    e.jsrc      = 1'b1;
    e.regdst    = 2'd2;
    e.memtoreg  = 2'd2;
    e.reg_write = 1'b1;
    e.retire    = 1'b1;
    cyc("jal:dec", 1'b0, 1'b1, e);

    set_ir(6'h00, 6'h08, 1'b0);
    fetch_ok("jr");
    e = st(SDecode);
    e.pc_write = 1'b1;
    e.jsrc     = 1'b1;
    e.jadr     = 1'b1;
    e.retire   = 1'b1;
    cyc("jr:dec", 1'b0, 1'b1, e);

    e = st(SDecode);
    e.retire = 1'b1;
    set_ir(6'h00, 6'h00, 1'b0);
    fetch_ok("nop"); cyc("nop:dec", 1'b0, 1'b1, e);
    set_ir(6'h3f, 6'h3f, 1'b0);
    fetch_ok("undef"); cyc("undef:dec", 1'b0, 1'b1, e);

    set_ir(6'h00, 6'h10, 1'b0);
    fetch_ok("mfhi"); dec_plain("mfhi"); wb("mfhi", 2'd1, 2'd3, 1'b1);
    set_ir(6'h00, 6'h12, 1'b0);
    fetch_ok("mflo"); dec_plain("mflo"); wb("mflo", 2'd1, 2'd3, 1'b0);

    set_ir(6'h00, 6'h18, 1'b0);
    fetch_ok("mult"); dec_plain("mult"); md_run("mult", 1'b0, 5);
    set_ir(6'h00, 6'h1b, 1'b0);
    fetch_ok("divu"); dec_plain("divu"); md_run("divu", 1'b1, 10);

    // divu aborted by reset on its third MDWAIT cycle
    fetch_ok("divu_rst"); dec_plain("divu_rst");
    e = st(SExec);
    e.md_start = 1'b1;
    e.md_op    = 1'b1;
    cyc("divu_rst:exec", 1'b0, 1'b1, e);
    e = st(SMdWait);
    e.md_busy = 1'b1;
    cyc("divu_rst:mdw0", 1'b0, 1'b1, e);
    cyc("divu_rst:mdw1", 1'b0, 1'b1, e);
    cyc("divu_rst:mdw2_rst", 1'b1, 1'b0, e);

    // sw aborted by reset while waiting in MEM
    set_ir(6'h2b, 6'h00, 1'b0);
    fetch_ok("sw_rst"); dec_plain("sw_rst"); exec("sw_rst", 1'b1, 2'd0, 2'd1);
    e = st(SMem);
    e.mem_write = 1'b1;
    cyc("sw_rst:mem0", 1'b0, 1'b1, e);
    cyc("sw_rst:mem1_rst", 1'b1, 1'b0, st(SMem));

    // Back to normal operation after the abort
    set_ir(6'h00, 6'h21, 1'b0);
    fetch_ok("addu2"); dec_plain("addu2"); exec("addu2", 1'b0, 2'd0, 2'd0);
    wb("addu2", 2'd1, 2'd0, 1'b0);

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
